// File: rtl/rob_retire_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// rob_retire_ctrl_pkg : shared ROB commit entry type, retire FSM states and the
//                       exception / serialising classification helper.
// Revision: 1.0
// =============================================================================
package rob_retire_ctrl_pkg;

    localparam int C_DATA_W = 32;
    localparam int C_AREG_W = 5;

    typedef struct packed {
        logic [C_DATA_W-1:0] pc;
        logic                w_reg;
        logic [C_AREG_W-1:0] arf_id;
        logic [C_DATA_W-1:0] w_data;
        logic                w_mem;
        logic                mem_ld;
        logic                is_uncached;
        logic                fetch_exception;
        logic                execute_exception;
        logic                syscall_inst;
        logic                break_inst;
        logic                decode_err;
        logic                flush_inst;
        logic                ertn_en;
        logic                idle_en;
        logic                is_csr_fix;
        logic                is_tlb_fix;
        logic                is_cache_fix;
    } rob_commit_pkg_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        UC_WAIT = 2'd1,
        FLUSH   = 2'd2,
        IDLE    = 2'd3
    } retire_state_e;

    typedef struct packed {
        logic exc;
        logic ser;
        logic uc;
    } retire_class_t;

    // An excepting memory op never issues its uncached access.
    function automatic retire_class_t classify_entry(input rob_commit_pkg_t e);
        retire_class_t c;
        c.exc = e.fetch_exception | e.execute_exception | e.syscall_inst
              | e.break_inst | e.decode_err;
        c.ser = c.exc | e.flush_inst | e.ertn_en | e.idle_en
              | e.is_csr_fix | e.is_tlb_fix | e.is_cache_fix;
        c.uc  = e.is_uncached & (e.mem_ld | e.w_mem) & ~c.exc;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_retire_ctrl.sv
`default_nettype none
// =============================================================================
// rob_retire_ctrl : in-order two-wide retirement at the ROB head, with ARF and
//                   store-buffer writeback, uncached serialisation and flushes.
// Revision: 1.0
// =============================================================================
module rob_retire_ctrl
    import rob_retire_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AREG_W = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   commit_valid_i,
    input  rob_commit_pkg_t [1:0]        commit_info_i,
    output logic [1:0]                   commit_req_o,
    output logic [1:0]                   arf_we_o,
    output logic [1:0][AREG_W-1:0]       arf_waddr_o,
    output logic [1:0][DATA_W-1:0]       arf_wdata_o,
    input  logic                         sb_ready_i,
    output logic                         sb_commit_o,
    output logic                         sb_slot_o,
    output logic                         uc_req_o,
    input  logic                         uc_ack_i,
    input  logic [DATA_W-1:0]            uc_rdata_i,
    input  logic [DATA_W-1:0]            exc_entry_i,
    input  logic [DATA_W-1:0]            era_i,
    input  logic                         int_pending_i,
    output logic                         exc_o,
    output logic                         flush_o,
    output logic [DATA_W-1:0]            redirect_pc_o,
    output logic                         idle_o
);

    retire_state_e       state_q, state_d;
    logic [DATA_W-1:0]   redirect_q, redirect_d;
    logic                flush_q, flush_d;
    logic                idle_q, idle_d;
    logic                uc_req_q, uc_req_d;

    retire_class_t       w_cls0, w_cls1;
    logic                w_st0, w_st1;
    logic                w_ret0_run, w_ret1_run;
    logic [1:0]          w_req;
    logic                w_uc_sel;
    logic                w_unused;

    assign w_cls0 = classify_entry(commit_info_i[0]);
    assign w_cls1 = classify_entry(commit_info_i[1]);

    // Only cached, non-excepting stores are handed to the store buffer.
    assign w_st0 = commit_info_i[0].w_mem & ~w_cls0.uc & ~w_cls0.exc;
    assign w_st1 = commit_info_i[1].w_mem & ~w_cls1.uc & ~w_cls1.exc;

    assign w_ret0_run = commit_valid_i[0] & ~w_cls0.uc & (~w_st0 | sb_ready_i);
    assign w_ret1_run = w_ret0_run & commit_valid_i[1]
                      & ~w_cls0.ser & ~w_cls1.ser & ~w_cls1.uc
                      & ~(commit_info_i[0].w_mem & commit_info_i[1].w_mem)
                      & (~w_st1 | sb_ready_i);

    assign w_unused = ^commit_info_i[1].pc;

    always_comb begin
        w_req       = 2'b00;
        w_uc_sel    = 1'b0;
        sb_commit_o = 1'b0;
        sb_slot_o   = 1'b0;
        exc_o       = 1'b0;
        state_d     = state_q;
        redirect_d  = redirect_q;
        uc_req_d    = uc_req_q;
        case (state_q)
            RUN: begin
                w_req       = {w_ret1_run, w_ret0_run};
                sb_commit_o = (w_ret0_run & w_st0) | (w_ret1_run & w_st1);
                sb_slot_o   = w_ret1_run & w_st1;
                exc_o       = w_ret0_run & w_cls0.exc;
                if (w_ret0_run && w_cls0.ser) begin
                    state_d = (commit_info_i[0].idle_en && !w_cls0.exc) ? IDLE : FLUSH;
                    if (w_cls0.exc)
                        redirect_d = exc_entry_i;
                    else if (commit_info_i[0].ertn_en)
                        redirect_d = era_i;
                    else
                        redirect_d = DATA_W'(commit_info_i[0].pc + C_DATA_W'(4));
                end else if (commit_valid_i[0] && w_cls0.uc) begin
                    state_d  = UC_WAIT;
                    uc_req_d = 1'b1;
                end
            end
            UC_WAIT: begin
                if (uc_ack_i) begin
                    w_req    = 2'b01;
                    w_uc_sel = 1'b1;
                    uc_req_d = 1'b0;
                    state_d  = RUN;
                end
            end
            FLUSH:   state_d = RUN;
            IDLE:    if (int_pending_i) state_d = FLUSH;
            default: state_d = RUN;
        endcase
        flush_d = (state_d == FLUSH);
        idle_d  = (state_d == IDLE);
    end

    assign commit_req_o = w_req;

    always_comb begin
        arf_we_o[0]    = w_req[0] & commit_info_i[0].w_reg
                       & (|commit_info_i[0].arf_id) & ~w_cls0.exc;
        arf_we_o[1]    = w_req[1] & commit_info_i[1].w_reg
                       & (|commit_info_i[1].arf_id) & ~w_cls1.exc;
        arf_waddr_o[0] = AREG_W'(commit_info_i[0].arf_id);
        arf_waddr_o[1] = AREG_W'(commit_info_i[1].arf_id);
        arf_wdata_o[0] = (w_uc_sel && commit_info_i[0].w_reg)
                       ? uc_rdata_i : DATA_W'(commit_info_i[0].w_data);
        arf_wdata_o[1] = DATA_W'(commit_info_i[1].w_data);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            redirect_q <= '0;
            flush_q    <= 1'b0;
            idle_q     <= 1'b0;
            uc_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            redirect_q <= redirect_d;
            flush_q    <= flush_d;
            idle_q     <= idle_d;
            uc_req_q   <= uc_req_d;
        end
    end

    assign flush_o       = flush_q;
    assign idle_o        = idle_q;
    assign uc_req_o      = uc_req_q;
    assign redirect_pc_o = redirect_q;

endmodule
`default_nettype wire

// File: tb/tb_rob_retire_ctrl.sv
`default_nettype none
// =============================================================================
// tb_rob_retire_ctrl : table-driven and sequence checks of rob_retire_ctrl.
// Revision: 1.0
// =============================================================================
module tb_rob_retire_ctrl;
    import rob_retire_ctrl_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [1:0]            commit_valid;
    rob_commit_pkg_t [1:0] info;
    logic [1:0]            commit_req, arf_we;
    logic [1:0][4:0]       arf_waddr;
    logic [1:0][31:0]      arf_wdata;
    logic                  sb_ready, sb_commit, sb_slot;
    logic                  uc_req, uc_ack;
    logic [31:0]           uc_rdata, exc_entry, era;
    logic                  int_pending, exc_out, flush, idle;
    logic [31:0]           redirect_pc;

    rob_retire_ctrl #(.DATA_W(32), .AREG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid_i(commit_valid), .commit_info_i(info),
        .commit_req_o(commit_req), .arf_we_o(arf_we),
        .arf_waddr_o(arf_waddr), .arf_wdata_o(arf_wdata),
        .sb_ready_i(sb_ready), .sb_commit_o(sb_commit), .sb_slot_o(sb_slot),
        .uc_req_o(uc_req), .uc_ack_i(uc_ack), .uc_rdata_i(uc_rdata),
        .exc_entry_i(exc_entry), .era_i(era), .int_pending_i(int_pending),
        .exc_o(exc_out), .flush_o(flush), .redirect_pc_o(redirect_pc),
        .idle_o(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  req, we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        sbc, sbs, exc, flush, idle, ucr;
        logic [31:0] rpc;
    } exp_t;

    typedef struct {
        string           name;
        logic [1:0]      v;
        rob_commit_pkg_t e0, e1;
        logic            sbr;
        logic [1:0]      req, we;
        logic            sbc, sbs;
    } vec_t;

    exp_t q[$];
    exp_t mx;
    int   n_vec = 0;
    int   n_err = 0;

    logic        s_rst = 1'b1, s_sbr = 1'b0, s_ack = 1'b0, s_intp = 1'b0;
    logic [31:0] s_rdata = '0;

    function automatic exp_t z(input string n);
        exp_t x;
        x.name = n; x.req = 2'b00; x.we = 2'b00; x.wa0 = '0; x.wa1 = '0;
        x.wd0 = '0; x.wd1 = '0; x.sbc = 1'b0; x.sbs = 1'b0; x.exc = 1'b0;
        x.flush = 1'b0; x.idle = 1'b0; x.ucr = 1'b0; x.rpc = '0;
        return x;
    endfunction

    function automatic rob_commit_pkg_t e_alu(input logic [31:0] pc, input logic [4:0] rd,
                                              input logic [31:0] d);
        rob_commit_pkg_t e;
        e = '0; e.pc = pc; e.w_reg = 1'b1; e.arf_id = rd; e.w_data = d;
        return e;
    endfunction

    function automatic rob_commit_pkg_t e_st(input logic [31:0] pc);
        rob_commit_pkg_t e;
        e = '0; e.pc = pc; e.w_mem = 1'b1;
        return e;
    endfunction

    function automatic rob_commit_pkg_t e_ucld(input logic [31:0] pc, input logic [4:0] rd);
        rob_commit_pkg_t e;
        e = e_alu(pc, rd, 32'h0); e.mem_ld = 1'b1; e.is_uncached = 1'b1;
        return e;
    endfunction

    task automatic chk(input string n, input string f, input logic [31:0] a, input logic [31:0] e);
        if (a !== e) begin
            n_err++;
            $display("FAIL %s %s: got %0h want %0h", n, f, a, e);
        end
    endtask

    task automatic cyc(input logic [1:0] v, input rob_commit_pkg_t e0,
                       input rob_commit_pkg_t e1, input exp_t x);
        @(posedge clk);
        #1;
        rst_n = s_rst; sb_ready = s_sbr; uc_ack = s_ack; uc_rdata = s_rdata;
        int_pending = s_intp; commit_valid = v; info[0] = e0; info[1] = e1;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mx = q.pop_front();
            n_vec++;
            chk(mx.name, "commit_req", 32'(commit_req), 32'(mx.req));
            chk(mx.name, "arf_we", 32'(arf_we), 32'(mx.we));
            if (mx.we[0]) begin
                chk(mx.name, "arf_waddr0", 32'(arf_waddr[0]), 32'(mx.wa0));
                chk(mx.name, "arf_wdata0", arf_wdata[0], mx.wd0);
            end
            if (mx.we[1]) begin
                chk(mx.name, "arf_waddr1", 32'(arf_waddr[1]), 32'(mx.wa1));
                chk(mx.name, "arf_wdata1", arf_wdata[1], mx.wd1);
            end
            chk(mx.name, "sb_commit", 32'(sb_commit), 32'(mx.sbc));
            if (mx.sbc) chk(mx.name, "sb_slot", 32'(sb_slot), 32'(mx.sbs));
            chk(mx.name, "exc", 32'(exc_out), 32'(mx.exc));
            chk(mx.name, "flush", 32'(flush), 32'(mx.flush));
            if (mx.flush) chk(mx.name, "redirect_pc", redirect_pc, mx.rpc);
            chk(mx.name, "idle", 32'(idle), 32'(mx.idle));
            chk(mx.name, "uc_req", 32'(uc_req), 32'(mx.ucr));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            tbl[14];
        exp_t            x;
        rob_commit_pkg_t a3, a5, a0, s0, s1, br, csr, nul, sys, sexc, ert, stc, idl, ucl;

        a3  = e_alu(32'h100, 5'd3, 32'h11);
        a5  = e_alu(32'h104, 5'd5, 32'h22);
        a0  = e_alu(32'h104, 5'd0, 32'h33);
        s0  = e_st(32'h110);
        s1  = e_st(32'h114);
        br  = e_alu(32'h100, 5'd9, 32'h44); br.w_reg = 1'b0;
        csr = e_alu(32'h104, 5'd6, 32'h55); csr.is_csr_fix = 1'b1;
        nul = '0;

        tbl[0]  = '{"alu2",        2'b11, a3, a5,  1'b0, 2'b11, 2'b11, 1'b0, 1'b0};
        tbl[1]  = '{"alu_r0_s0",   2'b11, a0, a5,  1'b0, 2'b11, 2'b10, 1'b0, 1'b0};
        tbl[2]  = '{"alu_r0_s1",   2'b11, a3, a0,  1'b0, 2'b11, 2'b01, 1'b0, 1'b0};
        tbl[3]  = '{"st_st_rdy",   2'b11, s0, s1,  1'b1, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[4]  = '{"st_second",   2'b01, s1, nul, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[5]  = '{"st_st_nordy", 2'b11, s0, s1,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{"alu_st",      2'b11, a3, s1,  1'b1, 2'b11, 2'b01, 1'b1, 1'b1};
        tbl[7]  = '{"alu_st_nordy",2'b11, a3, s1,  1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
        tbl[8]  = '{"s0_invalid",  2'b10, a3, a5,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[9]  = '{"s0_only",     2'b01, a3, a5,  1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
        tbl[10] = '{"ser_s1",      2'b11, a3, csr, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
        tbl[11] = '{"uc_s1",       2'b11, a3, e_ucld(32'h104, 5'd8), 1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
        tbl[12] = '{"nowrite_s0",  2'b11, br, a5,  1'b0, 2'b11, 2'b10, 1'b0, 1'b0};
        tbl[13] = '{"st_alu_nordy",2'b11, s0, a5,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0};

        exc_entry = 32'h1c008000; era = 32'h1c000abc;
        rst_n = 1'b0; commit_valid = 2'b00; info = '0; sb_ready = 1'b0;
        uc_ack = 1'b0; uc_rdata = '0; int_pending = 1'b0;
        repeat (3) @(posedge clk);

        cyc(2'b00, nul, nul, z("reset_state"));

        for (int i = 0; i < 14; i++) begin
            x = z(tbl[i].name);
            x.req = tbl[i].req; x.we = tbl[i].we;
            x.wa0 = tbl[i].e0.arf_id; x.wd0 = tbl[i].e0.w_data;
            x.wa1 = tbl[i].e1.arf_id; x.wd1 = tbl[i].e1.w_data;
            x.sbc = tbl[i].sbc; x.sbs = tbl[i].sbs;
            s_sbr = tbl[i].sbr;
            cyc(tbl[i].v, tbl[i].e0, tbl[i].e1, x);
        end
        s_sbr = 1'b0;

        // syscall in slot 0 retires alone and redirects to the exception entry
        sys = '0; sys.pc = 32'h1c000100; sys.syscall_inst = 1'b1;
        x = z("sys_retire"); x.req = 2'b01; x.exc = 1'b1;
        cyc(2'b11, sys, e_alu(32'h1c000104, 5'd4, 32'h1), x);
        x = z("sys_flush"); x.flush = 1'b1; x.rpc = 32'h1c008000;
        cyc(2'b11, a3, a5, x);
        cyc(2'b00, nul, nul, z("sys_after"));

        // excepting store must not reach the store buffer
        sexc = e_st(32'h400); sexc.execute_exception = 1'b1; s_sbr = 1'b1;
        x = z("stexc_retire"); x.req = 2'b01; x.exc = 1'b1;
        cyc(2'b01, sexc, nul, x);
        s_sbr = 1'b0;
        x = z("stexc_flush"); x.flush = 1'b1; x.rpc = 32'h1c008000;
        cyc(2'b00, nul, nul, x);

        ert = '0; ert.pc = 32'h500; ert.ertn_en = 1'b1;
        x = z("ertn_retire"); x.req = 2'b01;
        cyc(2'b01, ert, nul, x);
        x = z("ertn_flush"); x.flush = 1'b1; x.rpc = 32'h1c000abc;
        cyc(2'b00, nul, nul, x);

        // serialising store stalls without a flush until the store buffer is ready
        stc = e_st(32'h600); stc.is_cache_fix = 1'b1;
        cyc(2'b01, stc, nul, z("stser_stall"));
        s_sbr = 1'b1;
        x = z("stser_retire"); x.req = 2'b01; x.sbc = 1'b1; x.sbs = 1'b0;
        cyc(2'b01, stc, nul, x);
        s_sbr = 1'b0;
        x = z("stser_flush"); x.flush = 1'b1; x.rpc = 32'h604;
        cyc(2'b00, nul, nul, x);

        idl = '0; idl.pc = 32'h200; idl.idle_en = 1'b1;
        x = z("idle_retire"); x.req = 2'b01;
        cyc(2'b01, idl, nul, x);
        x = z("idle_wait"); x.idle = 1'b1;
        cyc(2'b00, nul, nul, x);
        cyc(2'b11, a3, a5, x);
        s_intp = 1'b1;
        cyc(2'b00, nul, nul, x);
        s_intp = 1'b0;
        x = z("idle_wake"); x.flush = 1'b1; x.rpc = 32'h204;
        cyc(2'b00, nul, nul, x);
        cyc(2'b00, nul, nul, z("idle_after"));

        ucl = e_ucld(32'h300, 5'd7);
        cyc(2'b01, ucl, nul, z("uc_first"));
        x = z("uc_wait"); x.ucr = 1'b1;
        for (int i = 0; i < 4; i++) cyc(2'b01, ucl, nul, x);
        s_ack = 1'b1; s_rdata = 32'hdeadbeef;
        x = z("uc_ack"); x.ucr = 1'b1; x.req = 2'b01; x.we = 2'b01;
        x.wa0 = 5'd7; x.wd0 = 32'hdeadbeef;
        cyc(2'b01, ucl, nul, x);
        s_ack = 1'b0;
        cyc(2'b00, nul, nul, z("uc_done"));

        // reset while waiting on the uncached access, then a stray ack
        cyc(2'b01, ucl, nul, z("rst_uc_first"));
        x = z("rst_uc_wait"); x.ucr = 1'b1;
        cyc(2'b01, ucl, nul, x);
        s_rst = 1'b0;
        cyc(2'b00, nul, nul, x);
        s_rst = 1'b1;
        cyc(2'b00, nul, nul, z("rst_cleared"));
        s_ack = 1'b1; s_rdata = 32'h12345678;
        cyc(2'b01, ucl, nul, z("stray_ack"));
        s_ack = 1'b0;
        x = z("rst_uc_rewait"); x.ucr = 1'b1;
        cyc(2'b01, ucl, nul, x);
        s_ack = 1'b1; s_rdata = 32'hcafef00d;
        x = z("rst_uc_ack"); x.ucr = 1'b1; x.req = 2'b01; x.we = 2'b01;
        x.wa0 = 5'd7; x.wd0 = 32'hcafef00d;
        cyc(2'b01, ucl, nul, x);
        s_ack = 1'b0;
        cyc(2'b00, nul, nul, z("rst_uc_done"));

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
